// File: rtl/fsk_demodulator.sv
// fsk_demodulator
//   Receive side of the 2-FSK link. The line toggles every HALF_FAST clk for a
//   mark (1) and every HALF_SLOW clk for a space (0). The line is synchronised,
//   the spacing between consecutive edges is measured, and each run is
//   classified against THRESH. A small IDLE/ACQ/LOCKED FSM qualifies the
//   stream before recovered bits are released.
//
// Ports
//   clk    : system clock
//   rst    : synchronous active-high reset
//   din    : modulated FSK line (asynchronous to clk phase)
//   dout   : recovered bit, holds the last legal classification
//   valid  : one-cycle pulse when dout is updated
//   locked : high while the FSM is in LOCKED
//   err    : one-cycle pulse on an illegal run or on loss of signal
//
// Build option
//   FSK_DEMOD_TOLERANT_EN : when defined, LOCKED survives one isolated bad run
//                           (err still pulses); a second consecutive bad run
//                           drops to ACQ.

module fsk_demodulator #(
   parameter int HALF_FAST = 4,
   parameter int HALF_SLOW = 8,
   parameter int THRESH    = 6,
   parameter int MIN_RUN   = 2,
   parameter int MAX_RUN   = 12,
   parameter int LOCK_CNT  = 2,
   parameter int CNT_W     = 5
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic dout,
   output logic valid,
   output logic locked,
   output logic err
);

   localparam int MATCH_W = $clog2(LOCK_CNT + 1);

   localparam logic [CNT_W-1:0]   CNT_SAT = CNT_W'(MAX_RUN + 1);
   localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(MAX_RUN);
   localparam logic [CNT_W-1:0]   CNT_MIN = CNT_W'(MIN_RUN);
   localparam logic [CNT_W-1:0]   CNT_THR = CNT_W'(THRESH);
   localparam logic [MATCH_W-1:0] MATCH_LOCK = MATCH_W'(LOCK_CNT);

   // Reject configurations where the nominal periods would not classify
   // cleanly or the run counter cannot hold the saturation value.
   if (!(HALF_FAST >= MIN_RUN && HALF_FAST < THRESH &&
         HALF_SLOW >= THRESH  && HALF_SLOW <= MAX_RUN &&
         MIN_RUN >= 1 && LOCK_CNT >= 1 &&
         (MAX_RUN + 1) < (1 << CNT_W))) begin : g_bad_cfg
      $error("fsk_demodulator: inconsistent parameter set");
   end

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACQ    = 2'd1,
      LOCKED = 2'd2
   } state_t;

   state_t               state, state_n;
   logic                 s1, s2, s3;
   logic [CNT_W-1:0]     cnt;
   logic [MATCH_W-1:0]   match, match_n;
   logic                 dout_n, valid_n, locked_n, err_n;
   logic                 din_edge, run_good, run_bit, timeout;
`ifdef FSK_DEMOD_TOLERANT_EN
   logic                 tol, tol_n;
`endif

   // s1/s2 form the synchroniser; s3 is the previous synchronised sample.
   assign din_edge = s2 ^ s3;

   // cnt holds the current run length L whenever an edge is seen.
   assign run_good = (cnt >= CNT_MIN) && (cnt <= CNT_MAX);
   assign run_bit  = (cnt < CNT_THR);
   // Fires only on the MAX_RUN -> MAX_RUN+1 step, so once per saturation;
   // an edge in the same cycle wins because it reloads the counter.
   assign timeout  = !din_edge && (cnt == CNT_MAX);

   always_ff @(posedge clk) begin
      if (rst) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
         s3 <= 1'b0;
         cnt <= CNT_SAT;
      end else begin
         s1 <= din;
         s2 <= s1;
         s3 <= s2;
         if (din_edge) begin
            cnt <= CNT_W'(1);
         end else if (cnt != CNT_SAT) begin
            cnt <= cnt + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         match  <= '0;
         dout   <= 1'b0;
         valid  <= 1'b0;
         locked <= 1'b0;
         err    <= 1'b0;
`ifdef FSK_DEMOD_TOLERANT_EN
         tol    <= 1'b0;
`endif
      end else begin
         state  <= state_n;
         match  <= match_n;
         dout   <= dout_n;
         valid  <= valid_n;
         locked <= locked_n;
         err    <= err_n;
`ifdef FSK_DEMOD_TOLERANT_EN
         tol    <= tol_n;
`endif
      end
   end

   always_comb begin
      state_n  = state;
      match_n  = match;
      dout_n   = dout;
      valid_n  = 1'b0;
      locked_n = locked;
      err_n    = 1'b0;
`ifdef FSK_DEMOD_TOLERANT_EN
      tol_n    = tol;
`endif

      unique case (state)
         IDLE: begin
            // The first edge only opens a run; its length is meaningless.
            if (din_edge) begin
               state_n = ACQ;
               match_n = '0;
            end
         end

         ACQ: begin
            if (din_edge) begin
               if (run_good) begin
                  if (match + MATCH_W'(1) == MATCH_LOCK) begin
                     // The run that completes acquisition is also delivered.
                     state_n  = LOCKED;
                     locked_n = 1'b1;
                     match_n  = '0;
                     dout_n   = run_bit;
                     valid_n  = 1'b1;
                  end else begin
                     match_n = match + MATCH_W'(1);
                  end
               end else begin
                  err_n   = 1'b1;
                  match_n = '0;
               end
            end else if (timeout) begin
               err_n   = 1'b1;
               match_n = '0;
               state_n = IDLE;
            end
         end

         LOCKED: begin
            if (din_edge) begin
               if (run_good) begin
                  dout_n  = run_bit;
                  valid_n = 1'b1;
`ifdef FSK_DEMOD_TOLERANT_EN
                  tol_n   = 1'b0;
`endif
               end else begin
                  err_n = 1'b1;
`ifdef FSK_DEMOD_TOLERANT_EN
                  if (!tol) begin
                     tol_n = 1'b1;
                  end else begin
                     tol_n    = 1'b0;
                     state_n  = ACQ;
                     locked_n = 1'b0;
                     match_n  = '0;
                  end
`else
                  state_n  = ACQ;
                  locked_n = 1'b0;
                  match_n  = '0;
`endif
               end
            end else if (timeout) begin
               err_n    = 1'b1;
               locked_n = 1'b0;
               match_n  = '0;
               state_n  = IDLE;
`ifdef FSK_DEMOD_TOLERANT_EN
               tol_n    = 1'b0;
`endif
            end
         end

         default: begin
            state_n  = IDLE;
            match_n  = '0;
            locked_n = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_fsk_demodulator.sv
// tb_fsk_demodulator
//   Directed bench for fsk_demodulator. din is changed on the falling edge
//   (after that edge's outputs are sampled), so the registered response to a
//   din toggle is visible on the third falling edge that follows it. The run
//   length classified at a toggle is the length of the preceding half.

module tb_fsk_demodulator;

   logic clk;
   logic rst;
   logic din;
   logic dout;
   logic valid;
   logic locked;
   logic err;

   int checks = 0;
   int errors = 0;

   fsk_demodulator #(
      .HALF_FAST(4),
      .HALF_SLOW(8),
      .THRESH(6),
      .MIN_RUN(2),
      .MAX_RUN(12),
      .LOCK_CNT(2),
      .CNT_W(5)
   ) dut (
      .clk(clk),
      .rst(rst),
      .din(din),
      .dout(dout),
      .valid(valid),
      .locked(locked),
      .err(err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One falling edge, then verify the valid/err pulses present there.
   task automatic step(input string tag, input logic ev, input logic ee);
      @(negedge clk);
      check({tag, "_valid"}, valid, ev);
      check({tag, "_err"}, err, ee);
   endtask

   // Toggle din and hold for len cycles. valid is expected only on cycle 3
   // (when ev), err only on cycle err_at (0 = never). The first offending
   // cycle index is reported as a single comparison.
   task automatic half(input string tag, input int len, input logic ev,
                       input logic ed, input int err_at, input logic el);
      int bad_at;
      bad_at = 0;
      din = ~din;
      for (int i = 1; i <= len; i++) begin
         @(negedge clk);
         if (bad_at == 0) begin
            if (valid !== ((i == 3) ? ev : 1'b0)) bad_at = i;
            if (err !== ((i == err_at) ? 1'b1 : 1'b0)) bad_at = i;
         end
         if (i == 3 && ev) check({tag, "_dout"}, dout, ed);
      end
      check({tag, "_pulse_cycle"}, bad_at, 0);
      check({tag, "_locked"}, locked, el);
   endtask

   initial begin
      rst = 1'b1;
      din = 1'b0;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_dout", dout, 1'b0);
      check("rst_valid", valid, 1'b0);
      check("rst_locked", locked, 1'b0);
      check("rst_err", err, 1'b0);
      rst = 1'b0;
      step("post_rst", 1'b0, 1'b0);

      // Mark acquisition: edge 1 -> ACQ, edges 2/3 good, lock on 3rd
      half("acq1", 4, 1'b0, 1'b0, 0, 1'b0);
      half("acq2", 4, 1'b0, 1'b0, 0, 1'b0);
      half("acq3", 4, 1'b1, 1'b1, 0, 1'b1);
      for (int k = 0; k < 7; k++) half("mark", 4, 1'b1, 1'b1, 0, 1'b1);

      // Switch to space; boundary runs around THRESH and at MAX_RUN
      half("sw_first", 8, 1'b1, 1'b1, 0, 1'b1);   // L=4
      half("space_a", 8, 1'b1, 1'b0, 0, 1'b1);    // L=8
      half("space_b", 8, 1'b1, 1'b0, 0, 1'b1);    // L=8
      half("space_c", 5, 1'b1, 1'b0, 0, 1'b1);    // L=8
      half("thr_m1", 6, 1'b1, 1'b1, 0, 1'b1);     // L=5
      half("thr_eq", 12, 1'b1, 1'b0, 0, 1'b1);    // L=6
      half("max_run", 4, 1'b1, 1'b0, 0, 1'b1);    // L=12, no timeout
      half("back_mark", 4, 1'b1, 1'b1, 0, 1'b1);  // L=4

      // 1-clk glitch inside a mark half: runs 4, 2 (good), 1 (bad), 4
      din = ~din;
      step("gl_m1", 1'b0, 1'b0);
      step("gl_m2", 1'b0, 1'b0);
      din = ~din;
      step("gl_m3", 1'b1, 1'b0);
      check("gl_m3_dout", dout, 1'b1);
      din = ~din;
      step("gl_m4", 1'b0, 1'b0);
      step("gl_m5", 1'b1, 1'b0);
      check("gl_m5_dout", dout, 1'b1);
      step("gl_m6", 1'b0, 1'b1);
      check("gl_m6_dout_held", dout, 1'b1);
`ifdef FSK_DEMOD_TOLERANT_EN
      check("gl_m6_locked", locked, 1'b1);
      step("gl_m7", 1'b0, 1'b0);
      half("gl_after1", 4, 1'b1, 1'b1, 0, 1'b1);
      half("gl_after2", 4, 1'b1, 1'b1, 0, 1'b1);
`else
      check("gl_m6_locked", locked, 1'b0);
      step("gl_m7", 1'b0, 1'b0);
      half("gl_relock1", 4, 1'b0, 1'b0, 0, 1'b0);
      half("gl_relock2", 4, 1'b1, 1'b1, 0, 1'b1);
`endif
      half("gl_mark", 4, 1'b1, 1'b1, 0, 1'b1);

      // Mid-stream reset while locked, with din low so no stray edge follows
      if (din) half("pre_rst", 4, 1'b1, 1'b1, 0, 1'b1);
      rst = 1'b1;
      @(negedge clk);
      check("mrst_dout", dout, 1'b0);
      check("mrst_valid", valid, 1'b0);
      check("mrst_locked", locked, 1'b0);
      check("mrst_err", err, 1'b0);
      rst = 1'b0;
      half("re_acq1", 4, 1'b0, 1'b0, 0, 1'b0);
      half("re_acq2", 4, 1'b0, 1'b0, 0, 1'b0);
      half("re_acq3", 4, 1'b1, 1'b1, 0, 1'b1);
      half("re_mark", 4, 1'b1, 1'b1, 0, 1'b1);

      // Loss of signal while locked: single err 15 cycles after last toggle
      half("timeout", 20, 1'b1, 1'b1, 15, 1'b0);

      // Toggling every 13 clk from IDLE: timeout err each run, never locked
      half("slow13_0", 13, 1'b0, 1'b0, 0, 1'b0);
      for (int k = 0; k < 3; k++) half("slow13", 13, 1'b0, 1'b0, 2, 1'b0);
      step("slow13_tail14", 1'b0, 1'b0);
      step("slow13_tail15", 1'b0, 1'b1);
      check("slow13_locked", locked, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fsk_demodulator.md
Name: fsk_demodulator

Overview:
- Receive-side counterpart of the 2-FSK modulator.
- Modulated line carries a square wave toggling every 4 clk (mark, bit 1) or every 8 clk (space, bit 0).
- Block synchronises the line, measures the interval between consecutive edges, and classifies each half-period as 1 or 0.
- Emits the recovered bit with a valid strobe, a lock indication and an error strobe to the downstream bit framer.

Parameters:
- HALF_FAST, 4, nominal mark half-period in clk cycles.
- HALF_SLOW, 8, nominal space half-period in clk cycles.
- THRESH, 6, decision threshold: run length L < THRESH is mark, otherwise space.
- MIN_RUN, 2, shortest legal run; L < MIN_RUN is a glitch.
- MAX_RUN, 12, longest legal run; reaching MAX_RUN+1 without an edge is loss of signal.
- LOCK_CNT, 2, consecutive legal runs required to enter LOCKED.
- CNT_W, 5, run counter width; must hold MAX_RUN+1.

Ports:
- clk, input, 1, system clock.
- rst, input, 1, synchronous active-high reset.
- din, input, 1, modulated FSK line, asynchronous to clk phase.
- dout, output, 1, recovered bit; holds last legal classification.
- valid, output, 1, one-cycle pulse when dout is updated.
- locked, output, 1, high while FSM is in LOCKED.
- err, output, 1, one-cycle pulse on an illegal run or on timeout.

Behaviour:
- Reset (rst high at posedge clk):
  - dout=0, valid=0, locked=0, err=0.
  - s1=s2=s3=0; cnt=MAX_RUN+1 (saturated); match=0; state IDLE.
- Synchroniser: s1<=din, s2<=s1, s3<=s2. edge = s2 XOR s3.
- Run counter:
  - On edge: L=cnt is sampled, then cnt<=1.
  - Otherwise cnt increments, saturating at MAX_RUN+1.
  - Edges 4 cycles apart give L=4.
- Classification of L:
  - L < MIN_RUN: bad.
  - MIN_RUN <= L < THRESH: good, bit 1.
  - THRESH <= L <= MAX_RUN: good, bit 0.
- Timeout: cnt transitions MAX_RUN to MAX_RUN+1 with no edge; fires once per saturation.
- FSM IDLE:
  - Edge -> ACQ, match=0; no valid, no err (L meaningless).
  - Timeouts ignored.
- FSM ACQ:
  - Good edge: match++. When match reaches LOCK_CNT -> LOCKED, locked=1, and this same edge emits valid with its bit.
  - Bad edge: err pulse, match=0, stay ACQ.
  - Timeout: err pulse -> IDLE.
- FSM LOCKED:
  - Good edge: dout<=bit, valid pulse.
  - Bad edge: err pulse, dout held, locked=0 -> ACQ with match=0.
  - Timeout: err pulse, locked=0 -> IDLE.
- Latency:
  - din toggle -> valid/dout/err registered 3 clk edges later (2 sync stages + output register).
  - valid and err are never high in the same cycle.
- Edge and timeout cannot coincide, because an edge resets cnt. Edge takes priority by construction.
- Mid-operation reset: all state and outputs return to reset values on the next edge; no pulse emitted in the reset cycle.
- Frequency switch: a mixed-length run at a mark/space boundary is classified by THRESH like any other run; no special case.

Optional Feature:
- Macro FSK_DEMOD_TOLERANT_EN.
- Defined:
  - In LOCKED, a single bad run gives an err pulse but keeps locked=1 and dout held.
  - A second consecutive bad run -> ACQ, locked=0.
  - Any good run clears the tolerance flag.
  - Timeout behaviour unchanged.
- Undefined: every bad run in LOCKED drops to ACQ immediately, as above.

Test Plan:
- Reset, then din toggling every 4 clk for 40 clk:
  - First edge -> ACQ; edges 2 and 3 -> locked=1 with valid pulse.
  - Every later edge gives valid with dout=1; first valid 3 clk after the 3rd din toggle.
- Lock on mark, then switch din to toggle every 8 clk:
  - Valid pulses with dout=0 every 8 clk; the boundary run (L in 4..8) is classified per THRESH.
  - No err.
- While locked, insert a 1-clk glitch pulse on din:
  - err pulse and drop to ACQ (locked=0); relock after 2 good runs.
  - With FSK_DEMOD_TOLERANT_EN: err pulse, locked stays 1.
- While locked, hold din constant for 20 clk:
  - Exactly one err pulse 13 clk after the last edge's internal detection; locked=0, state IDLE.
  - No further err.
- Assert rst for 1 clk while locked mid-stream:
  - Next cycle dout=0, valid=0, locked=0.
  - Resume toggling every 4 clk: requires first edge plus 2 good runs before valid.
- din toggling every 13 clk from IDLE:
  - Edge 1 -> ACQ; each later edge sees L>MAX_RUN, which is never reached because the timeout fires first.
  - err every run, never locked.
